// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S master transmitter (Philips timing, MSB first by default).
// Generates SCK and WS from clk_i and serializes one stereo beat per slot onto
// two data lines (sd0 carries the low word of sample_i, sd1 the high word).
//
// Optional build macro: I2S_TX_LSB_FIRST_EN adds cfg_lsb_first_i, latched with
// the other configuration on IDLE->RUN; when set, slots go out LSB first.
//
// Ports
//   clk_i, rst_i           system clock, synchronous active-high reset
//   cfg_en_i               1 = run, 0 = stop at the end of the current frame
//   cfg_div_i              SCK half-period minus 1, in clk cycles
//   cfg_word_len_i         slot length minus 1 (bits)
//   sample_i/_valid_i      {sd1_word, sd0_word}, word right-aligned at bit L-1
//   sample_ready_o         one-cycle pulse when a beat is loaded
//   master_*_o             SCK/WS/SD pad drive and output enables
//   underrun_o             one-cycle pulse when a slot starts without a beat
//   busy_o                 high while running
//
// State | meaning
// IDLE  | stopped, all outputs low, waiting for cfg_en_i
// RUN   | SCK running; lead period first, then left/right slots
module i2s_master_tx #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16,
  localparam int LW    = $clog2(DATA_W)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_en_i,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic [LW-1:0]       cfg_word_len_i,
`ifdef I2S_TX_LSB_FIRST_EN
  input  logic                cfg_lsb_first_i,
`endif
  input  logic [2*DATA_W-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  output logic                master_sck_out_o,
  output logic                master_sck_oe_o,
  output logic                master_ws_out_o,
  output logic                master_ws_oe_o,
  output logic                master_sd0_out_o,
  output logic                master_sd1_out_o,
  output logic                underrun_o,
  output logic                busy_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_q;
  logic [LW-1:0]     wl_q;
  logic [DIV_W-1:0]  cnt;
  logic [LW-1:0]     bit_cnt;
  logic              slot;     // 0 = left, 1 = right
  logic              lead;     // first SCK period after start, carries no data
  logic [DATA_W-1:0] sr0;
  logic [DATA_W-1:0] sr1;
  logic              lsb;
`ifdef I2S_TX_LSB_FIRST_EN
  logic              lsb_q;
`endif

  logic              tick;
  logic              fall;
  logic              slot_end;
  logic              stop;
  logic              new_slot;
  logic              nslot;
  logic [LW-1:0]     nbit;
  logic              ws_n;
  logic [DATA_W-1:0] src0;
  logic [DATA_W-1:0] src1;
  logic              bit0;
  logic              bit1;
  logic [DATA_W-1:0] sr0_n;
  logic [DATA_W-1:0] sr1_n;

  always_comb begin
`ifdef I2S_TX_LSB_FIRST_EN
    lsb      = lsb_q;
`else
    lsb      = 1'b0;
`endif
    tick     = (state == RUN) && (cnt == div_q);
    // SCK is high when the divider wraps, so this wrap is the falling edge
    fall     = tick && master_sck_out_o;
    slot_end = !lead && (bit_cnt == wl_q);
    stop     = fall && slot_end && slot && !cfg_en_i;
    new_slot = lead || slot_end;
    nslot    = lead ? 1'b0 : (slot_end ? ~slot : slot);
    nbit     = new_slot ? '0 : bit_cnt + LW'(1);
    // WS announces the next slot during the last period of the current one
    ws_n     = (nbit == wl_q) ? ~nslot : nslot;
    // On a slot start the bit source is the incoming beat (or zero on
    // underrun); otherwise it is the partially shifted register.
    src0     = new_slot ? (sample_valid_i ? sample_i[DATA_W-1:0] : '0) : sr0;
    src1     = new_slot ? (sample_valid_i ? sample_i[2*DATA_W-1:DATA_W] : '0) : sr1;
    bit0     = lsb ? src0[0] : src0[wl_q];
    bit1     = lsb ? src1[0] : src1[wl_q];
    sr0_n    = lsb ? (src0 >> 1) : (src0 << 1);
    sr1_n    = lsb ? (src1 >> 1) : (src1 << 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stop) begin
      state            <= IDLE;
      div_q            <= '0;
      wl_q             <= '0;
      cnt              <= '0;
      bit_cnt          <= '0;
      slot             <= 1'b0;
      lead             <= 1'b0;
      sr0              <= '0;
      sr1              <= '0;
`ifdef I2S_TX_LSB_FIRST_EN
      lsb_q            <= 1'b0;
`endif
      sample_ready_o   <= 1'b0;
      underrun_o       <= 1'b0;
      master_sck_out_o <= 1'b0;
      master_sck_oe_o  <= 1'b0;
      master_ws_out_o  <= 1'b0;
      master_ws_oe_o   <= 1'b0;
      master_sd0_out_o <= 1'b0;
      master_sd1_out_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      sample_ready_o <= 1'b0;
      underrun_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_en_i) begin
            state            <= RUN;
            div_q            <= cfg_div_i;
            wl_q             <= cfg_word_len_i;
`ifdef I2S_TX_LSB_FIRST_EN
            lsb_q            <= cfg_lsb_first_i;
`endif
            cnt              <= '0;
            bit_cnt          <= '0;
            slot             <= 1'b0;
            lead             <= 1'b1;
            master_sck_out_o <= 1'b0;
            master_ws_out_o  <= 1'b0;
            master_sd0_out_o <= 1'b0;
            master_sd1_out_o <= 1'b0;
            master_sck_oe_o  <= 1'b1;
            master_ws_oe_o   <= 1'b1;
            busy_o           <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            cnt              <= '0;
            master_sck_out_o <= ~master_sck_out_o;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
          if (fall) begin
            lead             <= 1'b0;
            slot             <= nslot;
            bit_cnt          <= nbit;
            master_ws_out_o  <= ws_n;
            master_sd0_out_o <= bit0;
            master_sd1_out_o <= bit1;
            sr0              <= sr0_n;
            sr1              <= sr1_n;
            if (new_slot) begin
              if (sample_valid_i) sample_ready_o <= 1'b1;
              else                underrun_o     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
module tb_i2s_master_tx;
  localparam int DATA_W = 32;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  cfg_div;
  logic [4:0]        wl;
  logic [63:0]       sample;
  logic              valid;
  logic              ready;
  logic              sck, sck_oe, ws, ws_oe, sd0, sd1;
  logic              underrun;
  logic              busy;
`ifdef I2S_TX_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [63:0] beats[$];
  bit          vld[$];

  always #5 clk = ~clk;

  i2s_master_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_en_i         (en),
    .cfg_div_i        (cfg_div),
    .cfg_word_len_i   (wl),
`ifdef I2S_TX_LSB_FIRST_EN
    .cfg_lsb_first_i  (lsb_first),
`endif
    .sample_i         (sample),
    .sample_valid_i   (valid),
    .sample_ready_o   (ready),
    .master_sck_out_o (sck),
    .master_sck_oe_o  (sck_oe),
    .master_ws_out_o  (ws),
    .master_ws_oe_o   (ws_oe),
    .master_sd0_out_o (sd0),
    .master_sd1_out_o (sd1),
    .underrun_o       (underrun),
    .busy_o           (busy)
  );

  // Source side: present each planned beat (or nothing) and wait for the DUT
  // to consume it. Drops cfg_en during the last frame so the run ends cleanly.
  task automatic drive(input int nslots, input int div, input int len, input int toggle_at);
    int          budget;
    logic [63:0] b;
    bit          v;
    bit          seen;
    logic [31:0] m;
    budget = 4 * len * (div + 1) + 100;
    m = 32'((64'd1 << len) - 1);
    for (int i = 0; i < nslots; i++) begin
      b = beats.pop_front();
      v = vld.pop_front();
      sample = b;
      valid  = v;
      exp_q.push_back(v ? {b[63:32] & m, b[31:0] & m} : 64'd0);
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
        @(negedge clk);
        if (v ? ready : underrun) begin
          seen = 1'b1;
          break;
        end
      end
      n_vec++;
      if (!seen) begin
        n_err++;
        $display("FAIL load_wait slot %0d: got no %s pulse, required one within %0d cycles",
                 i, v ? "ready" : "underrun", budget);
      end
      valid = 1'b0;
      if (i == toggle_at) begin
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
      end
      if (i == nslots - 2) en = 1'b0;
    end
  endtask

  // Pad side: receive on SCK rise, check timing against the configured
  // divider, and compare completed slots with the scoreboard.
  task automatic monitor(input int div, input int len, input int nslots,
                         input int n_rdy_exp, input int n_und_exp);
    int          per, half, t_run;
    int          rise_idx, last_rise, last_load, n_rdy, n_und, slots;
    int          b, s;
    bit          prev_sck;
    bit          run_exp;
    logic        ews;
    logic [31:0] a0, a1;
    logic [63:0] e;
    per = 2 * (div + 1);
    half = div + 1;
    t_run = per * (1 + nslots * len);
    rise_idx = 0; last_rise = 0; last_load = -1; n_rdy = 0; n_und = 0; slots = 0;
    prev_sck = 1'b0; a0 = '0; a1 = '0;
    for (int cyc = 1; cyc <= t_run + 4; cyc++) begin
      @(negedge clk);
      run_exp = (cyc <= t_run);
      n_vec++;
      if ({busy, sck_oe, ws_oe} !== {3{run_exp}}) begin
        n_err++;
        $display("FAIL busy_oe cyc %0d: got %b, required %b", cyc, {busy, sck_oe, ws_oe}, {3{run_exp}});
      end
      if (!run_exp) begin
        n_vec++;
        if ({sck, ws, sd0, sd1, ready, underrun} !== 6'b0) begin
          n_err++;
          $display("FAIL idle_outputs cyc %0d: got %b, required 000000", cyc,
                   {sck, ws, sd0, sd1, ready, underrun});
        end
      end
      if (ready || underrun) begin
        if (ready) n_rdy++;
        if (underrun) n_und++;
        n_vec++;
        if (last_load < 0 ? (cyc != per + 1) : (cyc - last_load != per * len)) begin
          n_err++;
          $display("FAIL load_timing cyc %0d: got gap %0d, required %0d", cyc,
                   last_load < 0 ? cyc : cyc - last_load, last_load < 0 ? per + 1 : per * len);
        end
        last_load = cyc;
      end
      if (sck && !prev_sck) begin
        if (rise_idx == 0) begin
          n_vec++;
          if ({ws, sd0, sd1} !== 3'b000 || cyc != half + 1) begin
            n_err++;
            $display("FAIL lead_period: got ws/sd %b at cyc %0d, required 000 at cyc %0d",
                     {ws, sd0, sd1}, cyc, half + 1);
          end
        end else begin
          b = (rise_idx - 1) % len;
          s = ((rise_idx - 1) / len) % 2;
          n_vec++;
          if (cyc - last_rise != per) begin
            n_err++;
            $display("FAIL sck_period: got %0d, required %0d", cyc - last_rise, per);
          end
          ews = (b == len - 1) ? (s == 0) : (s == 1);
          n_vec++;
          if (ws !== ews) begin
            n_err++;
            $display("FAIL ws slot %0d bit %0d: got %b, required %b", slots, b, ws, ews);
          end
          a0 = {a0[30:0], sd0};
          a1 = {a1[30:0], sd1};
          if (b == len - 1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL slot_data %0d: got %h_%h, required nothing (queue empty)", slots, a1, a0);
            end else begin
              e = exp_q.pop_front();
              if ({a1, a0} !== e) begin
                n_err++;
                $display("FAIL slot_data %0d: got %h_%h, required %h_%h", slots, a1, a0, e[63:32], e[31:0]);
              end
            end
            slots++;
            a0 = '0;
            a1 = '0;
          end
        end
        last_rise = cyc;
        rise_idx++;
      end
      prev_sck = sck;
    end
    n_vec++;
    if (slots != nslots || n_rdy != n_rdy_exp || n_und != n_und_exp) begin
      n_err++;
      $display("FAIL run_totals: got slots/ready/underrun %0d/%0d/%0d, required %0d/%0d/%0d",
               slots, n_rdy, n_und, nslots, n_rdy_exp, n_und_exp);
    end
  endtask

  task automatic run(input int div, input int len, input int nslots, input int toggle_at,
                     input int n_rdy, input int n_und);
    @(negedge clk);
    cfg_div = DIV_W'(div);
    wl      = 5'(len - 1);
    en      = 1'b1;
    fork
      drive(nslots, div, len, toggle_at);
      monitor(div, len, nslots, n_rdy, n_und);
    join
    exp_q.delete();
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_div = '0; wl = '0; sample = '0; valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({sck, sck_oe, ws, ws_oe, sd0, sd1, ready, underrun, busy} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 000000000",
               {sck, sck_oe, ws, ws_oe, sd0, sd1, ready, underrun, busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    beats.push_back({32'hC3C3_3C3C, 32'h5A5A_A5A5});
    vld.push_back(1'b1);
    beats.push_back({32'h0000_FEDC, 32'h0000_1234});
    vld.push_back(1'b1);
    run(1, 16, 2, -1, 2, 0);
  endtask

  task automatic test_underrun();
    beats.push_back({32'h0000_8001, 32'h0000_7FFE});
    vld.push_back(1'b1);
    beats.push_back({$urandom, $urandom});
    vld.push_back(1'b0);
    run(1, 16, 2, -1, 1, 1);
  endtask

  task automatic test_cfg_hold();
    for (int i = 0; i < 2; i++) begin
      beats.push_back({$urandom, $urandom});
      vld.push_back(1'b1);
    end
    fork
      run(1, 16, 2, -1, 2, 0);
      begin
        repeat (20) @(negedge clk);
        cfg_div = DIV_W'(3);
      end
    join
  endtask

  task automatic test_restart();
    for (int i = 0; i < 4; i++) begin
      beats.push_back({$urandom, $urandom});
      vld.push_back(1'b1);
    end
    run(3, 8, 4, -1, 4, 0);
  endtask

  task automatic test_reset_mid();
    int n_rdy;
    @(negedge clk);
    cfg_div = DIV_W'(1);
    wl      = 5'd15;
    sample  = {$urandom, $urandom};
    valid   = 1'b1;
    en      = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({sck, sck_oe, ws, ws_oe, sd0, sd1, ready, underrun, busy} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %b, required 000000000",
               {sck, sck_oe, ws, ws_oe, sd0, sd1, ready, underrun, busy});
    end
    rst = 1'b0;
    n_rdy = 0;
    repeat (80) begin
      @(negedge clk);
      if (ready || busy) n_rdy++;
    end
    n_vec++;
    if (n_rdy != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got %0d ready/busy cycles, required 0", n_rdy);
    end
    valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      beats.push_back({$urandom, $urandom});
      vld.push_back(1'b1);
    end
    run(0, 32, 200, 20, 200, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_div = '0; wl = '0; sample = '0; valid = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_cfg_hold();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
